// File: rtl/spi_slave_sync.sv
// SPI mode-0 slave endpoint with SCLK/CS/MOSI oversampled in the HCLK domain.
// Fixed-width MSB-first frames, single-entry TX holding register, short/overlong frame detection.
module spi_slave_sync #(
    parameter int               WIDTH      = 16,
    parameter logic [WIDTH-1:0] TX_DEFAULT = WIDTH'(16'h00FF)
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    input  logic             SCLK,
    input  logic             CS,
    input  logic             MOSI,
    output logic             MISO,
    output logic             MISO_OE,
    input  logic [WIDTH-1:0] TX_DATA,
    input  logic             TX_VALID,
    output logic             TX_READY,
    output logic [WIDTH-1:0] RX_DATA,
    output logic             RX_VALID,
    output logic             FRAME_ERR,
    output logic             BUSY
);

    localparam int            CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DONE   = 2'd2,
        ST_OVER   = 2'd3
    } state_t;

    logic [2:0]       sclk_sync_r;
    logic [2:0]       cs_sync_r;
    logic [1:0]       mosi_sync_r;
    logic [1:0]       settle_r;
    logic             armed_r;
    logic [WIDTH-1:0] hold_r;
    logic             tx_ready_r;
    state_t           state_r;
    logic [WIDTH-1:0] shift_r;
    logic [CW-1:0]    cnt_r;
    logic             miso_r;
    logic             busy_r;
    logic [WIDTH-1:0] rx_data_r;
    logic             rx_valid_r;
    logic             frame_err_r;

    logic             sclk_rise_s;
    logic             sclk_fall_s;
    logic             cs_rise_s;
    logic             cs_fall_s;
    logic             start_s;
    logic             tx_take_s;
    logic             last_bit_s;
    logic [WIDTH-1:0] load_s;
    logic [WIDTH-1:0] shifted_s;
    logic [CW-1:0]    cnt_next_s;

    // Two-flop synchronizers plus an edge-detect stage for SCLK and CS
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            sclk_sync_r <= 3'b000;
            cs_sync_r   <= 3'b111;
            mosi_sync_r <= 2'b00;
        end else begin
            sclk_sync_r <= {sclk_sync_r[1:0], SCLK};
            cs_sync_r   <= {cs_sync_r[1:0], CS};
            mosi_sync_r <= {mosi_sync_r[0], MOSI};
        end
    end

    assign sclk_rise_s = sclk_sync_r[1] & ~sclk_sync_r[2];
    assign sclk_fall_s = ~sclk_sync_r[1] & sclk_sync_r[2];
    assign cs_rise_s   = cs_sync_r[1] & ~cs_sync_r[2];
    assign cs_fall_s   = ~cs_sync_r[1] & cs_sync_r[2];

    // The CS flops reset high, so a CS pin held low through reset would look like a
    // falling edge; a frame may only open once synchronized CS has been seen high.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            settle_r <= 2'b00;
            armed_r  <= 1'b0;
        end else begin
            settle_r <= {settle_r[0], 1'b1};
            if (settle_r[1] && cs_sync_r[1]) begin
                armed_r <= 1'b1;
            end else begin
                armed_r <= armed_r;
            end
        end
    end

    assign start_s    = (state_r == ST_IDLE) && cs_fall_s && armed_r;
    assign tx_take_s  = TX_VALID && tx_ready_r;
    assign load_s     = tx_ready_r ? TX_DEFAULT : hold_r;
    assign shifted_s  = {shift_r[WIDTH-2:0], mosi_sync_r[1]};
    assign last_bit_s = (cnt_r == LAST_CNT);
    assign cnt_next_s = (cnt_r == FULL_CNT) ? cnt_r : (cnt_r + CNT_ONE);

    // Holding register: filled by the valid/ready handshake, emptied only at frame start
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            hold_r     <= {WIDTH{1'b0}};
            tx_ready_r <= 1'b1;
        end else begin
            if (tx_take_s) begin
                hold_r     <= TX_DATA;
                tx_ready_r <= 1'b0;
            end else if (start_s) begin
                tx_ready_r <= 1'b1;
            end else begin
                tx_ready_r <= tx_ready_r;
            end
        end
    end

    // Frame state machine; all of its outputs are registers
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_r     <= ST_IDLE;
            shift_r     <= {WIDTH{1'b0}};
            cnt_r       <= {CW{1'b0}};
            miso_r      <= 1'b0;
            busy_r      <= 1'b0;
            rx_data_r   <= {WIDTH{1'b0}};
            rx_valid_r  <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            rx_valid_r  <= 1'b0;
            frame_err_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        shift_r <= load_s;
                        miso_r  <= load_s[WIDTH-1];
                        cnt_r   <= {CW{1'b0}};
                        busy_r  <= 1'b1;
                        state_r <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (sclk_rise_s) begin
                        shift_r <= shifted_s;
                        cnt_r   <= cnt_next_s;
                    end
                    if (sclk_rise_s && last_bit_s) begin
                        rx_data_r  <= shifted_s;
                        rx_valid_r <= 1'b1;
                    end
                    // A CS rise in the same cycle as the final SCLK rise completes the frame
                    if (cs_rise_s) begin
                        frame_err_r <= !(sclk_rise_s && last_bit_s);
                        miso_r      <= 1'b0;
                        busy_r      <= 1'b0;
                        state_r     <= ST_IDLE;
                    end else if (sclk_rise_s && last_bit_s) begin
                        state_r <= ST_DONE;
                    end else if (sclk_fall_s) begin
                        miso_r <= shift_r[WIDTH-1];
                    end
                end
                ST_DONE: begin
                    if (cs_rise_s) begin
                        frame_err_r <= sclk_rise_s;
                        miso_r      <= 1'b0;
                        busy_r      <= 1'b0;
                        state_r     <= ST_IDLE;
                    end else if (sclk_rise_s) begin
                        miso_r  <= 1'b0;
                        state_r <= ST_OVER;
                    end else if (sclk_fall_s) begin
                        miso_r <= 1'b0;
                    end
                end
                ST_OVER: begin
                    miso_r <= 1'b0;
                    if (cs_rise_s) begin
                        frame_err_r <= 1'b1;
                        busy_r      <= 1'b0;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    miso_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign MISO      = miso_r;
    assign MISO_OE   = busy_r;
    assign BUSY      = busy_r;
    assign TX_READY  = tx_ready_r;
    assign RX_DATA   = rx_data_r;
    assign RX_VALID  = rx_valid_r;
    assign FRAME_ERR = frame_err_r;

endmodule

// File: tb/tb_spi_slave_sync.sv
// Bench for spi_slave_sync: directed frame table, reset-mid-frame sequence and
// randomized frames checked against a frame-level reference model.
module tb_spi_slave_sync;

    localparam int W  = 16;
    localparam int PH = 5;

    logic         HCLK     = 1'b0;
    logic         HRESETn  = 1'b1;
    logic         SCLK     = 1'b0;
    logic         CS       = 1'b1;
    logic         MOSI     = 1'b0;
    logic [W-1:0] TX_DATA  = 16'h0000;
    logic         TX_VALID = 1'b0;
    logic         MISO, MISO_OE, TX_READY, RX_VALID, FRAME_ERR, BUSY;
    logic [W-1:0] RX_DATA;

    int total = 0;
    int bad   = 0;
    int rxv_seen  = 0;
    int ferr_seen = 0;

    spi_slave_sync #(.WIDTH(W), .TX_DEFAULT(16'h00FF)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .SCLK(SCLK), .CS(CS), .MOSI(MOSI),
        .MISO(MISO), .MISO_OE(MISO_OE), .TX_DATA(TX_DATA), .TX_VALID(TX_VALID),
        .TX_READY(TX_READY), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID),
        .FRAME_ERR(FRAME_ERR), .BUSY(BUSY)
    );

    always #5 HCLK = ~HCLK;

    // Pulse counters, sampled on the inactive edge
    always @(negedge HCLK) begin
        if (RX_VALID === 1'b1) rxv_seen = rxv_seen + 1;
        if (FRAME_ERR === 1'b1) ferr_seen = ferr_seen + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    task automatic chk_reset(input string pfx);
        chk({pfx, "_miso"},      32'(MISO),      32'h0);
        chk({pfx, "_miso_oe"},   32'(MISO_OE),   32'h0);
        chk({pfx, "_tx_ready"},  32'(TX_READY),  32'h1);
        chk({pfx, "_rx_data"},   32'(RX_DATA),   32'h0);
        chk({pfx, "_rx_valid"},  32'(RX_VALID),  32'h0);
        chk({pfx, "_frame_err"}, 32'(FRAME_ERR), 32'h0);
        chk({pfx, "_busy"},      32'(BUSY),      32'h0);
    endtask

    task automatic sclk_pulse();
        repeat (PH) @(negedge HCLK);
        SCLK = 1'b1;
        repeat (PH) @(negedge HCLK);
        SCLK = 1'b0;
    endtask

    // Plays one master frame: optional TX offers, nbits MSB-first bits, CS release
    task automatic run_frame(input bit pre_tx, input logic [W-1:0] pre_word,
                             input bit mid_tx, input logic [W-1:0] mid_word,
                             input logic [31:0] mosi_bits, input int nbits, input bit cs_last,
                             output logic [31:0] miso_bits, output int rxv_n, output int ferr_n);
        int rxv0;
        int ferr0;
        miso_bits = 32'h0;
        rxv0  = rxv_seen;
        ferr0 = ferr_seen;
        if (pre_tx) begin
            @(negedge HCLK);
            TX_DATA  = pre_word;
            TX_VALID = 1'b1;
            @(negedge HCLK);
            TX_VALID = 1'b0;
            chk("tx_ready_after_offer", 32'(TX_READY), 32'h0);
        end
        @(negedge HCLK);
        CS = 1'b0;
        repeat (2) @(negedge HCLK);
        if (pre_tx) chk("tx_ready_before_cs_detect", 32'(TX_READY), 32'h0);
        @(negedge HCLK);
        if (pre_tx) chk("tx_ready_after_cs_detect", 32'(TX_READY), 32'h1);
        repeat (PH) @(negedge HCLK);
        chk("busy_oe_in_frame", 32'({BUSY, MISO_OE}), 32'h3);
        for (int i = nbits - 1; i >= 0; i--) begin
            MOSI = mosi_bits[i];
            if (mid_tx && i == nbits - 1) begin
                TX_DATA  = mid_word;
                TX_VALID = 1'b1;
            end
            repeat (PH) @(negedge HCLK);
            TX_VALID  = 1'b0;
            miso_bits = {miso_bits[30:0], MISO};
            SCLK = 1'b1;
            if (cs_last && i == 0) CS = 1'b1;
            repeat (PH) @(negedge HCLK);
            SCLK = 1'b0;
        end
        if (mid_tx && nbits > 0) chk("tx_ready_mid_held", 32'(TX_READY), 32'h0);
        repeat (PH) @(negedge HCLK);
        CS = 1'b1;
        repeat (PH + 2) @(negedge HCLK);
        chk("idle_after_frame", 32'({BUSY, MISO_OE, MISO}), 32'h0);
        rxv_n  = rxv_seen - rxv0;
        ferr_n = ferr_seen - ferr0;
    endtask

    typedef struct {
        bit          pre_tx;
        logic [15:0] pre_word;
        bit          mid_tx;
        logic [15:0] mid_word;
        logic [31:0] mosi;
        int          nbits;
        bit          cs_last;
        logic [31:0] exp_miso;
        int          exp_rxv;
        logic [15:0] exp_rx;
        int          exp_ferr;
    } vec_t;

    vec_t vecs[10];

    logic [31:0] mb;
    int          rn;
    int          fn;
    bit          m_full;
    logic [15:0] m_word;
    logic [15:0] m_rx;
    logic [15:0] loaded;
    logic [31:0] e_miso;
    logic [31:0] r_mosi;
    logic [15:0] r_pw;
    logic [15:0] r_mw;
    int          nb;
    bit          r_pre;
    bit          r_mid;
    bit          r_cl;
    int          r0;
    int          f0;

    initial begin
        vecs[0] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 32'h0000A5C3, 16, 1'b0, 32'h000000FF, 1, 16'hA5C3, 0};
        vecs[1] = '{1'b1, 16'h1234, 1'b0, 16'h0000, 32'h00003C3C, 16, 1'b0, 32'h00001234, 1, 16'h3C3C, 0};
        vecs[2] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 32'h0000A5C3, 16, 1'b0, 32'h000000FF, 1, 16'hA5C3, 0};
        vecs[3] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 32'h000001FF,  9, 1'b0, 32'h00000001, 0, 16'hA5C3, 1};
        vecs[4] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 32'h00001E1F, 17, 1'b0, 32'h000001FE, 1, 16'h0F0F, 1};
        vecs[5] = '{1'b1, 16'h9876, 1'b1, 16'h5555, 32'h00006666, 16, 1'b0, 32'h00009876, 1, 16'h6666, 0};
        vecs[6] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 32'h00000001, 16, 1'b0, 32'h00005555, 1, 16'h0001, 0};
        vecs[7] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 32'h0000FFFF, 16, 1'b1, 32'h000000FF, 1, 16'hFFFF, 0};
        vecs[8] = '{1'b1, 16'hABCD, 1'b0, 16'h0000, 32'h00000000,  4, 1'b0, 32'h0000000A, 0, 16'hFFFF, 1};
        vecs[9] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 32'h00008000, 16, 1'b0, 32'h000000FF, 1, 16'h8000, 0};

        // Reset must act with no clock edge
        #2 HRESETn = 1'b0;
        #2 chk_reset("rst");
        repeat (3) @(negedge HCLK);
        HRESETn = 1'b1;
        repeat (6) @(negedge HCLK);
        chk_reset("post_rst");

        for (int v = 0; v < 10; v++) begin
            run_frame(vecs[v].pre_tx, vecs[v].pre_word, vecs[v].mid_tx, vecs[v].mid_word,
                      vecs[v].mosi, vecs[v].nbits, vecs[v].cs_last, mb, rn, fn);
            chk($sformatf("vec%0d_miso", v),    mb,             vecs[v].exp_miso);
            chk($sformatf("vec%0d_rx_valid", v), 32'(rn),       32'(vecs[v].exp_rxv));
            chk($sformatf("vec%0d_rx_data", v), 32'(RX_DATA),   32'(vecs[v].exp_rx));
            chk($sformatf("vec%0d_frame_err", v), 32'(fn),      32'(vecs[v].exp_ferr));
        end

        // Reset in the middle of a frame with CS held low
        @(negedge HCLK);
        CS = 1'b0;
        repeat (2 * PH) @(negedge HCLK);
        for (int i = 0; i < 8; i++) begin
            MOSI = 1'($urandom);
            sclk_pulse();
        end
        repeat (2) @(negedge HCLK);
        chk("busy_before_reset", 32'(BUSY), 32'h1);
        #1 HRESETn = 1'b0;
        #1 chk_reset("midrst");
        @(negedge HCLK);
        @(negedge HCLK);
        HRESETn = 1'b1;
        r0 = rxv_seen;
        f0 = ferr_seen;
        for (int i = 0; i < 10; i++) begin
            MOSI = 1'($urandom);
            sclk_pulse();
        end
        repeat (PH) @(negedge HCLK);
        chk("ignored_busy_oe_miso", 32'({BUSY, MISO_OE, MISO}), 32'h0);
        chk("ignored_rx_valid", 32'(rxv_seen - r0), 32'h0);
        chk("ignored_frame_err", 32'(ferr_seen - f0), 32'h0);
        chk("ignored_rx_data", 32'(RX_DATA), 32'h0);
        CS = 1'b1;
        repeat (2 * PH) @(negedge HCLK);
        run_frame(1'b0, 16'h0000, 1'b0, 16'h0000, 32'h0000BEEF, 16, 1'b0, mb, rn, fn);
        chk("beef_miso", mb, 32'h000000FF);
        chk("beef_rx_data", 32'(RX_DATA), 32'h0000BEEF);
        chk("beef_rx_valid", 32'(rn), 32'h1);
        chk("beef_frame_err", 32'(fn), 32'h0);

        // Randomized frames against the frame-level model
        m_full = 1'b0;
        m_word = 16'h0000;
        m_rx   = 16'hBEEF;
        for (int k = 0; k < 30; k++) begin
            nb     = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 20)) : 16;
            r_pre  = !m_full && ($urandom_range(0, 1) == 1);
            r_mid  = (nb > 0) && ($urandom_range(0, 2) == 0);
            r_cl   = (nb <= 16) && ($urandom_range(0, 3) == 0);
            r_pw   = 16'($urandom);
            r_mw   = 16'($urandom);
            r_mosi = $urandom;

            loaded = r_pre ? r_pw : (m_full ? m_word : 16'h00FF);
            m_full = 1'b0;
            if (r_mid) begin
                m_full = 1'b1;
                m_word = r_mw;
            end
            e_miso = 32'h0;
            for (int j = 0; j < nb; j++) begin
                e_miso = {e_miso[30:0], (j < 16) ? loaded[15 - j] : 1'b0};
            end
            if (nb >= 16) m_rx = 16'(r_mosi >> (nb - 16));

            run_frame(r_pre, r_pw, r_mid, r_mw, r_mosi, nb, r_cl, mb, rn, fn);
            chk($sformatf("rnd%0d_miso", k), mb, e_miso);
            chk($sformatf("rnd%0d_rx_valid", k), 32'(rn), (nb >= 16) ? 32'h1 : 32'h0);
            chk($sformatf("rnd%0d_rx_data", k), 32'(RX_DATA), 32'(m_rx));
            chk($sformatf("rnd%0d_frame_err", k), 32'(fn), (nb != 16) ? 32'h1 : 32'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_slave_sync.md
Name: spi_slave_sync

Overview:
- Synchronous SPI slave endpoint: the downstream stage wired to the AHB SPI master's SCLK/CS/MOSI/MISO pins.
- Used as the on-chip loop-back target for SPI system tests and as the front end of a future sensor-emulation peripheral.
- All SPI inputs are oversampled in the HCLK domain. There is no second clock.
- Supports SPI mode 0 (CPOL=0, CPHA=0), MSB first, fixed frame width.

Parameters:
- WIDTH, 16, frame length in bits (2..32).
- TX_DEFAULT, 16'h00FF, word shifted out when no TX word is held (WIDTH bits).

Ports:
- HCLK  in  1  system clock; all logic on rising edge.
- HRESETn  in  1  asynchronous active-low reset.
- SCLK  in  1  SPI clock from master (asynchronous to HCLK).
- CS  in  1  chip select, active low.
- MOSI  in  1  serial data from master.
- MISO  out  1  serial data to master.
- MISO_OE  out  1  MISO output enable; high only while synchronized CS is low.
- TX_DATA  in  WIDTH  next word to return to the master.
- TX_VALID  in  1  TX_DATA offered.
- TX_READY  out  1  holding register empty.
- RX_DATA  out  WIDTH  last complete received frame.
- RX_VALID  out  1  one-cycle pulse when RX_DATA is updated.
- FRAME_ERR  out  1  one-cycle pulse on a short or overlong frame.
- BUSY  out  1  frame in progress (synchronized CS low).

Behaviour:
- Reset: applies immediately, with no clock required.
  - Outputs: MISO=0, MISO_OE=0, TX_READY=1, RX_DATA=0, RX_VALID=0, FRAME_ERR=0, BUSY=0.
  - Internal: shift register=0, bit count=0, holding empty, state IDLE.
  - Synchronizers: SCLK/MOSI flops reset to 0, CS flops reset to 1.
- Input sync: SCLK, CS and MOSI each pass through two flops, then a third flop for edge detection.
  - A pin edge acts exactly 3 HCLK cycles after it occurs.
  - Supported SCLK rate: at most HCLK/8. High and low phases must each be at least 4 HCLK cycles.
- TX holding register (valid/ready):
  - A word is accepted when TX_VALID & TX_READY; TX_READY then goes low the next cycle.
  - The register is emptied only at frame start. TX_READY returns high the cycle after the CS falling edge is detected.
  - A word offered during an active frame is held for the next frame.
- State machine IDLE -> ACTIVE -> (DONE | OVER) -> IDLE.
- IDLE:
  - On the CS falling-edge detect, load the shift register from the holding register if it is full, else from TX_DEFAULT.
  - Set count=0 and go to ACTIVE.
  - MISO = MSB of the loaded value, valid before the first SCLK rise.
- ACTIVE:
  - SCLK rising edge: shift in the synced MOSI at the LSB and increment count.
  - SCLK falling edge: the MISO register takes the next bit (shift register MSB after the shift).
  - When count reaches WIDTH: RX_DATA <= shift register (registered) and RX_VALID pulses in the same cycle, then go to DONE.
- DONE:
  - Any further SCLK rising edge while CS is low -> OVER. RX_DATA is retained and MISO is held at 0.
  - CS rising edge -> IDLE.
- OVER: on CS rising edge, pulse FRAME_ERR for 1 cycle and go to IDLE.
- CS rising in ACTIVE (count < WIDTH):
  - Discard the partial frame and pulse FRAME_ERR.
  - RX_DATA is unchanged and RX_VALID does not pulse. Go to IDLE.
  - If a TX word was consumed at this frame start, it is lost; it is not restored.
- Simultaneous CS rise and WIDTH-th SCLK rise in one cycle: the SCLK edge is processed first. RX_VALID pulses, FRAME_ERR does not, and the state returns to IDLE.
- BUSY = synchronized CS low. MISO_OE = BUSY. MISO=0 whenever MISO_OE=0.
- Count is a clog2(WIDTH+1)-bit counter that saturates at WIDTH and never wraps.
- Asynchronous reset mid-frame returns to IDLE. A later CS high-to-low edge is required to start a new frame.

Test Plan:
- Reset, hold TX_VALID=0, master sends 16'hA5C3 -> RX_DATA=16'hA5C3 with one RX_VALID pulse; master receives 16'h00FF on MISO; FRAME_ERR never asserted.
- TX_DATA=16'h1234 with TX_VALID pulse before the frame -> TX_READY low until the CS fall is detected, then high again; master receives 16'h1234; the next frame with no new word returns 16'h00FF.
- CS released after 9 SCLK pulses (MOSI all 1) -> FRAME_ERR pulses once, RX_VALID stays 0, RX_DATA keeps its previous value 16'hA5C3.
- 17 SCLK pulses with MOSI pattern 16'h0F0F then one extra 1 -> RX_VALID on the 16th bit with RX_DATA=16'h0F0F; FRAME_ERR pulses at CS rise.
- HRESETn pulsed low after 8 bits of a frame, with CS held low -> all outputs return to reset values at once; further SCLK edges are ignored until CS goes high then low; the next full frame 16'hBEEF is received correctly.
- TX word offered mid-frame (TX_DATA=16'h5555) -> current frame still returns the earlier loaded value; the following frame returns 16'h5555.
